// File: rtl/core_wb_regfile_if.sv
// Purpose: bundles the MEM/WB pipeline-register outputs, the two decode-stage
// read ports and the commit trace into one interface.
// Ports (signals):
//   master (pipeline/decode side) drives pc_i, instr_i, imm_i, rsd_idx_i,
//     alu_i, mem_data_i, reg_write_i, mem2reg_i, rs1_idx_i, rs2_idx_i and
//     observes rs1/rs2_data_o, wb_data_o and the commit_*/instret_o outputs.
//   slave (core_wb_regfile) sees the same signals with opposite directions.
interface core_wb_regfile_if #(
  parameter int XLEN = 64,
  parameter int PCW  = 32,
  parameter int IW   = 32,
  parameter int RIDX = 5
);
  logic [PCW-1:0]  pc_i;
  logic [IW-1:0]   instr_i;
  logic [XLEN-1:0] imm_i;
  logic [RIDX-1:0] rsd_idx_i;
  logic [XLEN-1:0] alu_i;
  logic [XLEN-1:0] mem_data_i;
  logic            reg_write_i;
  logic [2:0]      mem2reg_i;
  logic [RIDX-1:0] rs1_idx_i;
  logic [RIDX-1:0] rs2_idx_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic [XLEN-1:0] wb_data_o;
  logic            commit_valid_o;
  logic [PCW-1:0]  commit_pc_o;
  logic [RIDX-1:0] commit_rd_o;
  logic [XLEN-1:0] commit_data_o;
  logic [63:0]     instret_o;

  modport master (
    output pc_i, instr_i, imm_i, rsd_idx_i, alu_i, mem_data_i, reg_write_i,
           mem2reg_i, rs1_idx_i, rs2_idx_i,
    input  rs1_data_o, rs2_data_o, wb_data_o, commit_valid_o, commit_pc_o,
           commit_rd_o, commit_data_o, instret_o
  );

  modport slave (
    input  pc_i, instr_i, imm_i, rsd_idx_i, alu_i, mem_data_i, reg_write_i,
           mem2reg_i, rs1_idx_i, rs2_idx_i,
    output rs1_data_o, rs2_data_o, wb_data_o, commit_valid_o, commit_pc_o,
           commit_rd_o, commit_data_o, instret_o
  );
endinterface

// File: rtl/core_wb_regfile.sv
// Purpose: writeback stage. Selects the writeback value from the MEM/WB
// register, commits it to the integer register file (x0 reads as zero),
// serves two combinational read ports with same-cycle write bypass, and keeps
// a registered commit trace plus a 64-bit retired-instruction counter.
// Ports:
//   clk   - core clock, all state updates on the rising edge
//   rst_n - synchronous active-low reset
//   wb    - core_wb_regfile_if.slave (pipeline inputs, read ports, trace)
module core_wb_regfile #(
  parameter int XLEN         = 64,
  parameter int NREGS        = 32,
  parameter int RIDX         = 5,
  parameter int PCW          = 32,
  parameter int IW           = 32,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  core_wb_regfile_if.slave wb
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] pc_ext;
  logic [XLEN-1:0] wb_data;
  logic            rf_we;
  logic            retire;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  logic            commit_valid_q, commit_valid_d;
  logic [PCW-1:0]  commit_pc_q,    commit_pc_d;
  logic [RIDX-1:0] commit_rd_q,    commit_rd_d;
  logic [XLEN-1:0] commit_data_q,  commit_data_d;
  logic [63:0]     instret_q,      instret_d;

  // PC is zero-extended before any addition so results wrap at 2^XLEN.
  assign pc_ext = {{(XLEN-PCW){1'b0}}, wb.pc_i};

  always_comb begin
    wb_data = wb.alu_i;
    case (wb.mem2reg_i)
      3'b001:  wb_data = wb.mem_data_i;
      3'b010:  wb_data = pc_ext + XLEN'(4);
      3'b011:  wb_data = wb.imm_i;
      3'b100:  wb_data = pc_ext + wb.imm_i;
      default: wb_data = wb.alu_i;
    endcase
  end

  assign rf_we  = wb.reg_write_i && (wb.rsd_idx_i != '0);
  // A bubble still writes: the control bits of the pipeline register decide.
  assign retire = (wb.instr_i != '0);

  // Entry 0 is never written; the read muxes force it to zero anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLEAR_ON_RST) begin
        for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[wb.rsd_idx_i] <= wb_data;
    end
  end

  // Bypass uses rf_we, so a write aimed at x0 can never leak onto a port.
  always_comb begin
    rs1_data = rf_q[wb.rs1_idx_i];
    if (wb.rs1_idx_i == '0)
      rs1_data = '0;
    else if (rf_we && (wb.rsd_idx_i == wb.rs1_idx_i))
      rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = rf_q[wb.rs2_idx_i];
    if (wb.rs2_idx_i == '0)
      rs2_data = '0;
    else if (rf_we && (wb.rsd_idx_i == wb.rs2_idx_i))
      rs2_data = wb_data;
  end

  // On a bubble only the valid flag drops; the rest of the trace holds.
  always_comb begin
    commit_valid_d = retire;
    commit_pc_d    = commit_pc_q;
    commit_rd_d    = commit_rd_q;
    commit_data_d  = commit_data_q;
    instret_d      = instret_q;
    if (retire) begin
      commit_pc_d   = wb.pc_i;
      commit_rd_d   = rf_we ? wb.rsd_idx_i : '0;
      commit_data_d = rf_we ? wb_data : '0;
      instret_d     = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
      instret_q      <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
      instret_q      <= instret_d;
    end
  end

  assign wb.wb_data_o      = wb_data;
  assign wb.rs1_data_o     = rs1_data;
  assign wb.rs2_data_o     = rs2_data;
  assign wb.commit_valid_o = commit_valid_q;
  assign wb.commit_pc_o    = commit_pc_q;
  assign wb.commit_rd_o    = commit_rd_q;
  assign wb.commit_data_o  = commit_data_q;
  assign wb.instret_o      = instret_q;

endmodule

// File: tb/tb_core_wb_regfile.sv
// Purpose: self-checking bench for core_wb_regfile. A behavioural model
// (plain array + counters) predicts every output; a compare process checks
// them on each falling edge, together with a few hand-computed expectations.
module tb_core_wb_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_wb_regfile_if bus ();

  core_wb_regfile dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (bus)
  );

  // behavioural model state
  logic [63:0] m_regs [32];
  logic        m_cv;
  logic [31:0] m_cpc;
  logic [4:0]  m_crd;
  logic [63:0] m_cdata;
  logic [63:0] m_instret;
  bit          started = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          what;
    logic [63:0] exp;
    string       name;
  } pin_t;
  pin_t pin_q[$];

  localparam int P_WB = 0, P_RS1 = 1, P_CDATA = 2, P_CRD = 3, P_INSTRET = 4,
                 P_CV = 5;

  function automatic logic [63:0] f_wb(input logic [2:0] sel, input logic [31:0] pc,
                                       input logic [63:0] imm, input logic [63:0] alu,
                                       input logic [63:0] md);
    logic [63:0] pcx;
    pcx = {32'd0, pc};
    if (sel == 3'd1) return md;
    if (sel == 3'd2) return pcx + 64'd4;
    if (sel == 3'd3) return imm;
    if (sel == 3'd4) return pcx + imm;
    return alu;
  endfunction

  function automatic logic [63:0] f_rd(input logic [4:0] idx, input logic [63:0] wbv);
    if (idx == 5'd0) return 64'd0;
    if (bus.reg_write_i && bus.rsd_idx_i == idx) return wbv;
    return m_regs[idx];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (started) begin
      logic [63:0] w;
      pin_t p;
      w = f_wb(bus.mem2reg_i, bus.pc_i, bus.imm_i, bus.alu_i, bus.mem_data_i);
      chk("wb_data", bus.wb_data_o, w);
      chk("rs1_data", bus.rs1_data_o, f_rd(bus.rs1_idx_i, w));
      chk("rs2_data", bus.rs2_data_o, f_rd(bus.rs2_idx_i, w));
      chk("commit_valid", {63'd0, bus.commit_valid_o}, {63'd0, m_cv});
      chk("commit_pc", {32'd0, bus.commit_pc_o}, {32'd0, m_cpc});
      chk("commit_rd", {59'd0, bus.commit_rd_o}, {59'd0, m_crd});
      chk("commit_data", bus.commit_data_o, m_cdata);
      chk("instret", bus.instret_o, m_instret);
      while (pin_q.size() > 0) begin
        p = pin_q.pop_front();
        case (p.what)
          P_WB:      chk(p.name, bus.wb_data_o, p.exp);
          P_RS1:     chk(p.name, bus.rs1_data_o, p.exp);
          P_CDATA:   chk(p.name, bus.commit_data_o, p.exp);
          P_CRD:     chk(p.name, {59'd0, bus.commit_rd_o}, p.exp);
          P_INSTRET: chk(p.name, bus.instret_o, p.exp);
          default:   chk(p.name, {63'd0, bus.commit_valid_o}, p.exp);
        endcase
      end
    end
  end

  task automatic pin(input int what, input logic [63:0] exp, input string name);
    pin_t p;
    p.what = what;
    p.exp  = exp;
    p.name = name;
    pin_q.push_back(p);
  endtask

  // advance one rising edge, updating the model from the applied inputs
  task automatic tick();
    logic [63:0] w;
    @(posedge clk);
    w = f_wb(bus.mem2reg_i, bus.pc_i, bus.imm_i, bus.alu_i, bus.mem_data_i);
    if (!rst_n) begin
      m_cv = 1'b0; m_cpc = '0; m_crd = '0; m_cdata = '0; m_instret = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      if (bus.reg_write_i && bus.rsd_idx_i != 5'd0) m_regs[bus.rsd_idx_i] = w;
      if (bus.instr_i != 32'd0) begin
        m_cv    = 1'b1;
        m_cpc   = bus.pc_i;
        m_crd   = (bus.reg_write_i && bus.rsd_idx_i != 5'd0) ? bus.rsd_idx_i : 5'd0;
        m_cdata = (bus.reg_write_i && bus.rsd_idx_i != 5'd0) ? w : 64'd0;
        m_instret = m_instret + 64'd1;
      end else begin
        m_cv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.pc_i = '0; bus.instr_i = '0; bus.imm_i = '0; bus.rsd_idx_i = '0;
    bus.alu_i = '0; bus.mem_data_i = '0; bus.reg_write_i = 1'b0;
    bus.mem2reg_i = '0; bus.rs1_idx_i = '0; bus.rs2_idx_i = '0;
  endtask

  initial begin
    logic [2:0] sels [5];
    logic [63:0] sel_exp [5];
    idle();
    rst_n = 1'b0;
    tick();
    started = 1'b1;
    tick();
    rst_n = 1'b1;
    pin(P_INSTRET, 64'd0, "reset_instret");
    pin(P_CV, 64'd0, "reset_commit_valid");

    // read every index after reset
    for (int i = 0; i < 32; i++) begin
      bus.rs1_idx_i = 5'(i);
      bus.rs2_idx_i = 5'(31 - i);
      pin(P_RS1, 64'd0, "reset_read");
      tick();
    end

    // ALU write with same-cycle bypass
    bus.instr_i = 32'h13; bus.reg_write_i = 1'b1; bus.rsd_idx_i = 5'd5;
    bus.mem2reg_i = 3'b000; bus.alu_i = 64'hDEAD_BEEF_0000_0001; bus.rs1_idx_i = 5'd5;
    pin(P_RS1, 64'hDEAD_BEEF_0000_0001, "alu_bypass");
    tick();
    idle();
    bus.rs1_idx_i = 5'd5;
    pin(P_RS1, 64'hDEAD_BEEF_0000_0001, "alu_stored");
    pin(P_CRD, 64'd5, "alu_commit_rd");
    pin(P_CDATA, 64'hDEAD_BEEF_0000_0001, "alu_commit_data");
    pin(P_INSTRET, 64'd1, "alu_instret");
    tick();

    // source mux
    sels[0] = 3'b010; sel_exp[0] = 64'h8000_0004;
    sels[1] = 3'b100; sel_exp[1] = 64'h8000_0010;
    sels[2] = 3'b011; sel_exp[2] = 64'h10;
    sels[3] = 3'b001; sel_exp[3] = 64'hFFFF_FFFF_FFFF_FF80;
    sels[4] = 3'b111; sel_exp[4] = 64'h0BAD;
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.pc_i = 32'h8000_0000; bus.imm_i = 64'h10; bus.alu_i = 64'h0BAD;
      bus.mem_data_i = 64'hFFFF_FFFF_FFFF_FF80; bus.mem2reg_i = sels[i];
      pin(P_WB, sel_exp[i], "mux_select");
      tick();
    end

    // write to x0 is dropped
    idle();
    bus.instr_i = 32'h13; bus.reg_write_i = 1'b1; bus.rsd_idx_i = 5'd0;
    bus.alu_i = 64'h1234; bus.rs1_idx_i = 5'd0;
    pin(P_RS1, 64'd0, "x0_read");
    tick();
    idle();
    pin(P_CRD, 64'd0, "x0_commit_rd");
    pin(P_CDATA, 64'd0, "x0_commit_data");
    pin(P_CV, 64'd1, "x0_commit_valid");

    // alternate retire / bubble
    for (int i = 0; i < 10; i++) begin
      bus.instr_i = (i % 2 == 0) ? 32'h13 : 32'h0;
      tick();
    end
    idle();
    pin(P_INSTRET, 64'd7, "alternate_instret");
    tick();

    // counter wrap
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    tick();
    bus.instr_i = 32'h13;
    tick();
    idle();
    pin(P_INSTRET, 64'd0, "instret_wrap");
    tick();

    // mid-stream reset blocks the write
    bus.instr_i = 32'h13; bus.reg_write_i = 1'b1; bus.rsd_idx_i = 5'd7;
    bus.alu_i = 64'hAAAA;
    tick();
    rst_n = 1'b0;
    bus.alu_i = 64'h5555;
    tick();
    rst_n = 1'b1;
    idle();
    bus.rs1_idx_i = 5'd7;
    pin(P_RS1, 64'd0, "reset_no_write");
    pin(P_INSTRET, 64'd0, "reset_clears_instret");
    pin(P_CV, 64'd0, "reset_clears_valid");
    pin(P_CRD, 64'd0, "reset_clears_rd");
    tick();
    bus.instr_i = 32'h13; bus.reg_write_i = 1'b1; bus.rsd_idx_i = 5'd7;
    bus.alu_i = 64'h77;
    tick();
    idle();
    bus.rs1_idx_i = 5'd7;
    pin(P_RS1, 64'h77, "post_reset_write");
    pin(P_INSTRET, 64'd1, "post_reset_instret");
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n           = ($urandom_range(0, 39) != 0);
      bus.pc_i        = $urandom;
      bus.instr_i     = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      bus.imm_i       = {$urandom, $urandom};
      bus.rsd_idx_i   = 5'($urandom_range(0, 31));
      bus.alu_i       = {$urandom, $urandom};
      bus.mem_data_i  = {$urandom, $urandom};
      bus.reg_write_i = 1'($urandom_range(0, 1));
      bus.mem2reg_i   = 3'($urandom_range(0, 7));
      bus.rs1_idx_i   = ($urandom_range(0, 3) == 0) ? bus.rsd_idx_i : 5'($urandom_range(0, 31));
      bus.rs2_idx_i   = ($urandom_range(0, 3) == 0) ? bus.rs1_idx_i : 5'($urandom_range(0, 31));
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_wb_regfile.md
Name: core_wb_regfile

Overview:
- Writeback end of the MEM/WB pipeline boundary.
- Consumes the MEM/WB register outputs and selects the writeback value by `mem2reg`.
- Commits that value into the 32-entry architectural integer register file (x0 hardwired to zero).
- Serves the two decode-stage read ports with same-cycle write bypass, and provides a registered commit trace plus a 64-bit retired-instruction counter.

Parameters:
- XLEN, `OPERAND_WIDTH (64): register and data width.
- NREGS, 32: number of architectural registers; index width `CPU_RFIDX_WIDTH (5).
- CLEAR_ON_RST, 1: 1 = all registers cleared on reset; 0 = contents retained across reset, only outputs/counter reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pc_i  in  `CPU_PC_SIZE  PC of instruction in WB
- instr_i  in  `CPU_INSTR_SIZE  instruction in WB; 0 = bubble
- imm_i  in  XLEN  immediate
- rsd_idx_i  in  5  destination register index
- alu_i  in  XLEN  ALU result
- mem_data_i  in  XLEN  load data, already extended
- reg_write_i  in  1  write enable
- mem2reg_i  in  3  writeback source select
- rs1_idx_i  in  5  read port 1 index
- rs2_idx_i  in  5  read port 2 index
- rs1_data_o  out  XLEN  read port 1 data (combinational)
- rs2_data_o  out  XLEN  read port 2 data (combinational)
- wb_data_o  out  XLEN  selected writeback value (combinational, for forwarding)
- commit_valid_o  out  1  registered: instruction retired last cycle
- commit_pc_o  out  `CPU_PC_SIZE  registered PC of retired instruction
- commit_rd_o  out  5  registered rd (0 when no write)
- commit_data_o  out  XLEN  registered written value (0 when no write)
- instret_o  out  64  retired-instruction count

Behaviour:
- Source select `mem2reg_i`:
  - 000 → alu_i
  - 001 → mem_data_i
  - 010 → pc_i+4
  - 011 → imm_i
  - 100 → pc_i+imm_i
  - 101–111 → alu_i (reserved)
- Arithmetic is modulo 2^XLEN; pc_i is zero-extended to XLEN before adding.
- Write: on rising clk with rst_n=1, if reg_write_i=1 and rsd_idx_i≠0, regs[rsd_idx_i] ← wb_data_o. Writes to x0 are dropped.
- Read: rsN_data_o = 0 if rsN_idx_i=0; else wb_data_o if reg_write_i=1 and rsd_idx_i=rsN_idx_i (bypass); else regs[rsN_idx_i]. Zero added latency.
- Both read ports may hit the same index or the bypass simultaneously; both return the identical value.
- Retire: an instruction retires in a cycle iff instr_i≠0. On that edge:
  - commit_valid_o←1, commit_pc_o←pc_i.
  - commit_rd_o←(reg_write_i && rsd_idx_i≠0) ? rsd_idx_i : 0.
  - commit_data_o←the same gating applied to wb_data_o, else 0.
  - instret_o←instret_o+1, wrapping from 2^64−1 to 0.
- Bubble cycle (instr_i=0): commit_valid_o←0, other commit outputs hold; instret_o holds. reg_write_i with instr_i=0 still writes the register file (the pipeline register's control bits are authoritative).
- Reset (rst_n=0 at an edge, including mid-stream):
  - commit_valid_o, commit_pc_o, commit_rd_o, commit_data_o and instret_o all ← 0.
  - If CLEAR_ON_RST=1, all regs ← 0.
  - No write occurs in a reset cycle even if reg_write_i=1.
- Reads stay combinational during reset, reflecting pre-edge contents.

Test Plan:
- Reset then read all 32 indices → all 0; instret_o=0; commit_valid_o=0.
- ALU write: reg_write_i=1, rsd_idx_i=5, mem2reg_i=000, alu_i=0xDEAD_BEEF_0000_0001, rs1_idx_i=5 same cycle → rs1_data_o bypasses the value. Next cycle: regs[5] holds it; commit_rd_o=5, commit_data_o equals the value, instret_o=1.
- Source mux: pc_i=0x8000_0000, imm_i=0x10.
  - mem2reg 010 → 0x8000_0004.
  - mem2reg 100 → 0x8000_0010.
  - mem2reg 011 → 0x10.
  - mem2reg 001 with mem_data_i=0xFFFF_FFFF_FFFF_FF80 → that value.
  - mem2reg 111 → alu_i.
- x0 write: rsd_idx_i=0, reg_write_i=1, alu_i=0x1234, instr_i≠0 → rs1_data_o at idx 0 stays 0; commit_rd_o=0, commit_data_o=0, commit_valid_o=1.
- Bubble vs retire: alternate instr_i=0x00000013 and 0 for 10 cycles → instret_o=5; commit_valid_o toggles one cycle delayed. Preload instret to 2^64−1 via a force → wraps to 0.
- Reset mid-stream: assert rst_n=0 for one cycle with reg_write_i=1, rsd_idx_i=7 → regs[7] not written, commit outputs and instret_o cleared. Release → the next write succeeds.
